// File: rtl/fir_pkg.sv
// Shared widths, FSM states and saturation helpers for the time-multiplexed FIR.
package fir_pkg;

    localparam int N_TAPS_DEF = 4;
    localparam int DW_DEF     = 8;
    localparam int CW_DEF     = 8;
    localparam int OW_DEF     = 16;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    // Accumulator width that cannot overflow over N_TAPS full-precision products.
    function automatic int acc_width(input int dw, input int cw, input int n_taps);
        return dw + cw + $clog2(n_taps);
    endfunction

    function automatic logic signed [63:0] sat_max(input int ow);
        return (64'sd1 <<< (ow - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int ow);
        return -(64'sd1 <<< (ow - 1));
    endfunction

    function automatic logic saturates(input logic signed [63:0] v, input int ow);
        return (v > sat_max(ow)) || (v < sat_min(ow));
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int ow);
        if (v > sat_max(ow)) begin
            return sat_max(ow);
        end else if (v < sat_min(ow)) begin
            return sat_min(ow);
        end
        return v;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate register: clr zeroes, en adds x*h; acc_next is the pre-register sum.
// Single-cycle; no flow control of its own, the scheduler gates it with en.
module fir_mac_unit #(
    parameter int DW = 8,
    parameter int CW = 8,
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] x,
    input  logic [CW-1:0] h,
    output logic [AW-1:0] acc,
    output logic [AW-1:0] acc_next
);

    logic signed [DW+CW-1:0] prod;

    assign prod     = (DW+CW)'($signed(x)) * (DW+CW)'($signed(h));
    assign acc_next = acc + AW'(prod);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/fir_tap_scheduler.sv
// Time-multiplexed FIR: one shared MAC walks N_TAPS taps per sample, result saturated to OW bits.
// Latency N_TAPS+1 clocks accept-to-out_valid; in_ready low while busy, result held until out_ready.
module fir_tap_scheduler
    import fir_pkg::*;
#(
    parameter int N_TAPS = N_TAPS_DEF,
    parameter int DW     = DW_DEF,
    parameter int CW     = CW_DEF,
    parameter int OW     = OW_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DW-1:0]             in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OW-1:0]             out_data,
    output logic                      out_sat,
    input  logic                      coef_we,
    input  logic [$clog2(N_TAPS)-1:0] coef_addr,
    input  logic [CW-1:0]             coef_data,
    output logic                      coef_err,
    output logic                      busy
);

    localparam int              AW       = acc_width(DW, CW, N_TAPS);
    localparam int              TW       = $clog2(N_TAPS);
    localparam logic [TW-1:0]   LAST_TAP = TW'(N_TAPS - 1);

    state_t                state_q, state_d;
    logic [TW-1:0]         tap_q;
    logic [DW-1:0]         xline [N_TAPS];
    logic [CW-1:0]         coef  [N_TAPS];
    logic                  accept, mac_en, last_tap, coef_ok;
    logic [AW-1:0]         mac_acc, mac_acc_next;
    logic signed [63:0]    acc_wide;

    // Gated by reset_n so the producer never sees ready while the block is held in reset.
    assign in_ready  = (state_q == IDLE) && reset_n;
    assign accept    = in_valid && in_ready;
    assign mac_en    = (state_q == MAC);
    assign last_tap  = mac_en && (tap_q == LAST_TAP);
    assign coef_ok   = coef_we && (state_q == IDLE) && (int'(coef_addr) < N_TAPS);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign acc_wide  = 64'($signed(mac_acc_next));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = MAC;
            MAC:     if (last_tap)  state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tap_q    <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
            coef_err <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) begin
                xline[k] <= '0;
                coef[k]  <= CW'(1);
            end
        end else begin
            coef_err <= coef_we && !coef_ok;
            if (coef_ok) begin
                coef[coef_addr] <= coef_data;
            end
            if (accept) begin
                xline[0] <= in_data;
                for (int k = 1; k < N_TAPS; k++) begin
                    xline[k] <= xline[k-1];
                end
                tap_q <= '0;
            end else if (mac_en) begin
                tap_q <= tap_q + TW'(1);
            end
            // Final tap: capture the clipped sum straight from the adder output.
            if (last_tap) begin
                out_data <= OW'(saturate(acc_wide, OW));
                out_sat  <= saturates(acc_wide, OW);
            end
        end
    end

    fir_mac_unit #(
        .DW (DW),
        .CW (CW),
        .AW (AW)
    ) u_mac (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (accept),
        .en       (mac_en),
        .x        (xline[tap_q]),
        .h        (coef[tap_q]),
        .acc      (mac_acc),
        .acc_next (mac_acc_next)
    );

    // Every sample must start from a cleared accumulator.
    a_acc_clear_at_tap0: assert property (@(posedge clk) disable iff (!reset_n)
        (mac_en && tap_q == '0) |-> (mac_acc == '0));

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Directed bench for fir_tap_scheduler: sum-of-products reference model plus pinned literal results.
module tb_fir_tap_scheduler;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset_n, in_valid, in_ready, out_valid, out_ready, out_sat;
    logic        coef_we, coef_err, busy;
    logic [7:0]  in_data, coef_data;
    logic [15:0] out_data;
    logic [1:0]  coef_addr;

    logic        t3_in_valid, t3_in_ready, t3_out_valid, t3_out_ready, t3_out_sat;
    logic        t3_coef_we, t3_coef_err, t3_busy;
    logic [7:0]  t3_in_data, t3_coef_data;
    logic [15:0] t3_out_data;
    logic [1:0]  t3_coef_addr;

    always #5 clk = ~clk;

    fir_tap_scheduler u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err), .busy(busy)
    );

    fir_tap_scheduler #(.N_TAPS(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .in_valid(t3_in_valid), .in_ready(t3_in_ready),
        .in_data(t3_in_data), .out_valid(t3_out_valid), .out_ready(t3_out_ready),
        .out_data(t3_out_data), .out_sat(t3_out_sat), .coef_we(t3_coef_we),
        .coef_addr(t3_coef_addr), .coef_data(t3_coef_data), .coef_err(t3_coef_err),
        .busy(t3_busy)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: y = sum h[k]*x[k] over the sample history, clipped to 16 bits.
    typedef struct { int data; int sat; int cyc; } exp_t;
    int   hist [N];
    int   hm   [N];
    exp_t exp_q[$];
    int   log_data[$];
    int   log_sat[$];

    int imp_exp  [5] = '{1, 2, 2, 1, 0};
    int step_exp [5] = '{100, 300, 500, 600, 600};

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            hist[k] = 0;
            hm[k]   = 1;
        end
    endfunction

    task automatic model_accept(input int v);
        longint sum;
        exp_t   e;
        for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = v;
        sum = 0;
        for (int k = 0; k < N; k++) sum += longint'(hist[k]) * longint'(hm[k]);
        if (sum > 32767) begin
            e.data = 32767;  e.sat = 1;
        end else if (sum < -32768) begin
            e.data = -32768; e.sat = 1;
        end else begin
            e.data = int'(sum); e.sat = 0;
        end
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    function automatic int log_d(input int idx);
        return (idx < log_data.size()) ? log_data[idx] : 999999;
    endfunction

    function automatic int log_s(input int idx);
        return (idx < log_sat.size()) ? log_sat[idx] : 999999;
    endfunction

    task automatic send(input int v, input bit with_we = 1'b0,
                        input int waddr = 0, input int wval = 0);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1);
            return;
        end
        in_valid = 1'b1;
        in_data  = 8'(v);
        if (with_we) begin
            coef_we   = 1'b1;
            coef_addr = 2'(waddr);
            coef_data = 8'(wval);
            hm[waddr] = wval;
        end
        model_accept(v);
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        if (with_we) check("coef_err_with_sample", coef_err, 0);
    endtask

    task automatic write_coef(input int addr, input int val, input bit ok);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 2'(addr);
        coef_data = 8'(val);
        if (ok) hm[addr] = val;
        @(negedge clk);
        coef_we = 1'b0;
        check("coef_err", coef_err, ok ? 0 : 1);
        @(negedge clk);
        check("coef_err_clear", coef_err, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("idle_timeout", in_ready, 1);
    endtask

    // Compare process: every presented result against the model, and held stable under stall.
    bit presenting = 1'b0;
    int cur_d, cur_s;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (out_valid) begin
            if (!presenting) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("latency", cyc - e.cyc, N + 1);
                    check("out_data", $signed(out_data), e.data);
                    check("out_sat", out_sat, e.sat);
                    cur_d = e.data;
                    cur_s = e.sat;
                    log_data.push_back(int'($signed(out_data)));
                    log_sat.push_back(int'(out_sat));
                end
            end else begin
                check("hold_data", $signed(out_data), cur_d);
                check("hold_sat", out_sat, cur_s);
            end
            check("in_ready_in_out", in_ready, 0);
            check("busy_in_out", busy, 1);
            presenting = !out_ready;
        end else if (presenting) begin
            check("valid_dropped", out_valid, 1);
            presenting = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000 ns");
        $fatal(1);
    end

    initial begin
        int base, t_prev, n;
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        t3_in_valid = 1'b0; t3_in_data = '0; t3_out_ready = 1'b1;
        t3_coef_we = 1'b0; t3_coef_addr = '0; t3_coef_data = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_coef_err", coef_err, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst3_in_ready", t3_in_ready, 0);
        check("rst3_outputs", {t3_out_valid, t3_out_sat, t3_busy, t3_coef_err, t3_out_data}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);

        // Impulse with coefficients 1,2,2,1, back-to-back at full rate
        write_coef(0, 1, 1); write_coef(1, 2, 1); write_coef(2, 2, 1); write_coef(3, 1, 1);
        base = log_data.size();
        send(1);
        t_prev = cyc;
        for (int i = 0; i < 4; i++) begin
            send(0);
            check("throughput", cyc - t_prev, N + 2);
            t_prev = cyc;
        end
        wait_idle();
        for (int i = 0; i < 5; i++) check("impulse", log_d(base + i), imp_exp[i]);

        // Step
        base = log_data.size();
        repeat (5) send(100);
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            check("step", log_d(base + i), step_exp[i]);
            check("step_sat", log_s(base + i), 0);
        end

        // Saturation both ways
        for (int k = 0; k < N; k++) write_coef(k, 127, 1);
        base = log_data.size();
        repeat (4) send(-128);
        repeat (4) send(127);
        wait_idle();
        check("sat_neg", log_d(base + 3), -32768);
        check("sat_neg_flag", log_s(base + 3), 1);
        check("sat_pos", log_d(base + 7), 32767);
        check("sat_pos_flag", log_s(base + 7), 1);

        // Backpressure: hold the result for 10 cycles
        @(posedge clk); #1 out_ready = 1'b0;
        send(5);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", out_valid, 1);
        repeat (10) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_idle", in_ready, 1);
        check("bp_release_valid", out_valid, 0);

        // Coefficient rules: busy write rejected, write with sample takes effect
        write_coef(0, 1, 1); write_coef(1, 2, 1); write_coef(2, 2, 1); write_coef(3, 1, 1);
        base = log_data.size();
        repeat (4) send(0);
        send(10);
        write_coef(0, 50, 0);
        wait_idle();
        send(1);
        send(7, 1'b1, 0, 3);
        wait_idle();
        check("coef_first", log_d(base + 4), 10);
        check("coef_busy_ignored", log_d(base + 5), 21);
        check("coef_with_sample", log_d(base + 6), 43);

        // Out-of-range address on a 3-tap instance
        @(negedge clk);
        t3_coef_we = 1'b1; t3_coef_addr = 2'd3; t3_coef_data = 8'd9;
        @(negedge clk);
        t3_coef_we = 1'b0;
        check("n3_addr3_err", t3_coef_err, 1);
        @(negedge clk);
        check("n3_err_clear", t3_coef_err, 0);
        t3_coef_we = 1'b1; t3_coef_addr = 2'd2; t3_coef_data = 8'd9;
        @(negedge clk);
        t3_coef_we = 1'b0;
        check("n3_addr2_ok", t3_coef_err, 0);

        // Reset in the middle of the MAC sweep
        send(4);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_sat", out_sat, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_coef_err", coef_err, 0);
        repeat (3) @(negedge clk);
        check("midrst_hold_valid", out_valid, 0);
        reset_n = 1'b1;
        base = log_data.size();
        send(1);
        wait_idle();
        check("post_reset", log_d(base), 1);
        check("pending_results", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
